// File: rtl/xspi_mem_responder.sv
// Memory-side responder for the SDR octal SPI link: decodes cmd/addr/dummy/data
// phases, returns reads with a DQS strobe and stores page-program data in a byte array.
module xspi_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int PAGE_SIZE_LOG2 = 4,
  parameter int DUMMY_CYCLES   = 8
) (
  input  logic       mem_clk,
  input  logic       reset,
  input  logic       sclk_en,
  input  logic       cs_n,
  input  logic [7:0] dq_in,
  input  logic       dq_oe_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       dqs,
  output logic       busy,
  output logic       cmd_err,
  output logic       bus_conflict
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, STATUS, IGNORE
  } state_t;

  state_t                    state;
  logic [7:0]                mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [MEM_ADDR_WIDTH-1:0] addr_inc;
  logic [MEM_ADDR_WIDTH-1:0] page_next;
  logic [1:0]                byte_cnt;
  logic [4:0]                dummy_cnt;
  logic                      is_read;
  logic                      wel;
  logic                      mem_we;

  assign addr_inc  = addr + MEM_ADDR_WIDTH'(1);
  // Program offset wraps inside the current page; page bits stay fixed.
  assign page_next = {addr[MEM_ADDR_WIDTH-1:PAGE_SIZE_LOG2],
                      addr[PAGE_SIZE_LOG2-1:0] + PAGE_SIZE_LOG2'(1)};
  assign mem_we    = (state == WR_DATA) && !cs_n && sclk_en && wel;

  assign busy         = (state != IDLE);
  assign bus_conflict = dq_oe & dq_oe_in;

  always_ff @(posedge mem_clk) begin
    if (mem_we) mem[addr] <= dq_in;
  end

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      dqs       <= 1'b0;
      cmd_err   <= 1'b0;
      wel       <= 1'b0;
      addr      <= '0;
      byte_cnt  <= '0;
      dummy_cnt <= '0;
      is_read   <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_n) begin
        // Deselect wins over any qualified byte in the same cycle.
        if (state == WR_DATA) wel <= 1'b0;
        state <= IDLE;
        dq_oe <= 1'b0;
        dqs   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= CMD;
          CMD: if (sclk_en) begin
            byte_cnt <= '0;
            case (dq_in)
              8'h0B: begin is_read <= 1'b1; state <= ADDR; end
              8'h02: begin is_read <= 1'b0; state <= ADDR; end
              8'h05: begin
                dq_out <= {6'b0, wel, 1'b0};
                dq_oe  <= 1'b1;
                dqs    <= ~dqs;
                state  <= STATUS;
              end
              8'h06:   begin wel <= 1'b1; state <= IGNORE; end
              8'h04:   begin wel <= 1'b0; state <= IGNORE; end
              default: begin cmd_err <= 1'b1; state <= IGNORE; end
            endcase
          end
          ADDR: if (sclk_en) begin
            addr     <= MEM_ADDR_WIDTH'({addr, dq_in});
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_read) begin
                state     <= DUMMY;
                dummy_cnt <= 5'(DUMMY_CYCLES);
              end else begin
                state <= WR_DATA;
              end
            end
          end
          DUMMY: if (sclk_en) begin
            if (dummy_cnt == 5'd1) begin
              dummy_cnt <= '0;
              dq_out    <= mem[addr];
              dq_oe     <= 1'b1;
              dqs       <= ~dqs;
              state     <= RD_DATA;
            end else begin
              dummy_cnt <= dummy_cnt - 5'd1;
            end
          end
          RD_DATA: if (sclk_en) begin
            addr   <= addr_inc;
            dq_out <= mem[addr_inc];
            dqs    <= ~dqs;
          end
          WR_DATA: if (sclk_en) addr <= page_next;
          STATUS: if (sclk_en) begin
            dq_out <= {6'b0, wel, 1'b0};
            dqs    <= ~dqs;
          end
          IGNORE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xspi_mem_responder.sv
// Directed bench for xspi_mem_responder: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed per scenario.
module tb_xspi_mem_responder;

  logic       mem_clk = 1'b0;
  logic       reset;
  logic       sclk_en;
  logic       cs_n;
  logic [7:0] dq_in;
  logic       dq_oe_in;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       dqs;
  logic       busy;
  logic       cmd_err;
  logic       bus_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  xspi_mem_responder #(
    .MEM_ADDR_WIDTH(8),
    .PAGE_SIZE_LOG2(4),
    .DUMMY_CYCLES  (8)
  ) dut (
    .mem_clk     (mem_clk),
    .reset       (reset),
    .sclk_en     (sclk_en),
    .cs_n        (cs_n),
    .dq_in       (dq_in),
    .dq_oe_in    (dq_oe_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .dqs         (dqs),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .bus_conflict(bus_conflict)
  );

  always #5 mem_clk = ~mem_clk;

  // ---- stimulus helpers (drive only) ----
  task automatic send(input logic [7:0] b);
    dq_in   = b;
    sclk_en = 1'b1;
    @(negedge mem_clk);
    sclk_en = 1'b0;
  endtask

  task automatic cs_start();
    cs_n    = 1'b0;
    sclk_en = 1'b0;
    @(negedge mem_clk);
  endtask

  task automatic cs_end();
    cs_n    = 1'b1;
    sclk_en = 1'b0;
    @(negedge mem_clk);
  endtask

  task automatic send_addr(input logic [31:0] a);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
  endtask

  task automatic set_wel();
    cs_start(); send(8'h06); cs_end();
  endtask

  task automatic prog_bytes(input logic [31:0] a, input logic [31:0] d, input int n);
    cs_start(); send(8'h02); send_addr(a);
    for (int i = 0; i < n; i++) send(d[31-8*i -: 8]);
    cs_end();
  endtask

  task automatic read_cmd(input logic [31:0] a);
    cs_start(); send(8'h0B); send_addr(a);
  endtask

  task automatic read_start(input logic [31:0] a);
    read_cmd(a);
    repeat (8) send(8'h00);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    n_checks++;
    if ({dq_out, dq_oe, dqs, busy, cmd_err, bus_conflict} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: dq_out=%h oe=%b dqs=%b busy=%b err=%b conf=%b, expected all 0",
               dq_out, dq_oe, dqs, busy, cmd_err, bus_conflict);
    end
  endtask

  task automatic test_wel_program();
    logic [7:0] exp [4];
    logic       ed;
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    set_wel();
    cs_start(); send(8'h05);
    n_checks++;
    if (dq_out !== 8'h02 || dq_oe !== 1'b1 || dqs !== 1'b1) begin
      n_fail++;
      $display("FAIL status_wel1: dq_out=%h oe=%b dqs=%b, expected 02 1 1", dq_out, dq_oe, dqs);
    end
    send(8'h00);
    n_checks++;
    if (dq_out !== 8'h02 || dqs !== 1'b0) begin
      n_fail++;
      $display("FAIL status_repeat: dq_out=%h dqs=%b, expected 02 0", dq_out, dqs);
    end
    cs_end();
    prog_bytes(32'h0000_0020, 32'hA0A1_A2A3, 4);
    read_cmd(32'h0000_0020);
    for (int i = 0; i < 7; i++) begin
      send(8'h00);
      n_checks++;
      if (dq_oe !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL dummy_quiet[%0d]: oe=%b busy=%b, expected 0 1", i, dq_oe, busy);
      end
    end
    send(8'h00);
    for (int i = 0; i < 4; i++) begin
      ed = ((i % 2) == 0);
      n_checks++;
      if (dq_out !== exp[i] || dq_oe !== 1'b1 || dqs !== ed) begin
        n_fail++;
        $display("FAIL prog_read[%0d]: dq_out=%h oe=%b dqs=%b, expected %h 1 %b",
                 i, dq_out, dq_oe, dqs, exp[i], ed);
      end
      if (i < 3) send(8'h00);
    end
    cs_end();
    n_checks++;
    if (dq_oe !== 1'b0 || dqs !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_end: oe=%b dqs=%b busy=%b, expected 0 0 0", dq_oe, dqs, busy);
    end
    cs_start(); send(8'h05);
    n_checks++;
    if (dq_out !== 8'h00 || dq_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL status_wel_cleared: dq_out=%h oe=%b, expected 00 1", dq_out, dq_oe);
    end
    cs_end();
  endtask

  task automatic test_program_no_wel();
    set_wel();
    prog_bytes(32'h0000_0040, 32'h7700_0000, 1);
    prog_bytes(32'h0000_0040, 32'h5500_0000, 1);
    read_start(32'h0000_0040);
    n_checks++;
    if (dq_out !== 8'h77) begin
      n_fail++;
      $display("FAIL no_wel_discard: dq_out=%h, expected 77", dq_out);
    end
    cs_end();
  endtask

  task automatic test_page_wrap();
    logic [7:0] exp [5];
    logic [7:0] a [5];
    exp = '{8'h01, 8'h02, 8'h77, 8'h03, 8'h04};
    a   = '{8'h3E, 8'h3F, 8'h40, 8'h30, 8'h31};
    set_wel();
    prog_bytes(32'h0000_003E, 32'h0102_0304, 4);
    for (int i = 0; i < 5; i++) begin
      read_start({24'h0, a[i]});
      n_checks++;
      if (dq_out !== exp[i]) begin
        n_fail++;
        $display("FAIL page_wrap[%h]: dq_out=%h, expected %h", a[i], dq_out, exp[i]);
      end
      cs_end();
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    set_wel();
    prog_bytes(32'h0000_00FE, 32'h1122_0000, 2);
    set_wel();
    prog_bytes(32'h0000_0000, 32'h3300_0000, 1);
    read_start(32'h1234_56FE);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dq_out !== exp[i]) begin
        n_fail++;
        $display("FAIL read_wrap[%0d]: dq_out=%h, expected %h", i, dq_out, exp[i]);
      end
      if (i < 2) send(8'h00);
    end
    cs_end();
  endtask

  task automatic test_abort();
    read_cmd(32'h0000_0020);
    send(8'h00);
    cs_n = 1'b1; sclk_en = 1'b1; dq_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge mem_clk);
      n_checks++;
      if (dq_oe !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_dummy[%0d]: oe=%b busy=%b, expected 0 0", i, dq_oe, busy);
      end
    end
    sclk_en = 1'b0;
    // deselect together with a program byte: byte must not land
    set_wel();
    prog_bytes(32'h0000_0050, 32'h5A00_0000, 1);
    set_wel();
    cs_start(); send(8'h02); send_addr(32'h0000_0050);
    cs_n = 1'b1; sclk_en = 1'b1; dq_in = 8'hEE;
    @(negedge mem_clk);
    sclk_en = 1'b0;
    read_start(32'h0000_0050);
    n_checks++;
    if (dq_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_write: dq_out=%h, expected 5A", dq_out);
    end
    cs_end();
  endtask

  task automatic test_illegal();
    cs_start(); send(8'h9F);
    n_checks++;
    if (cmd_err !== 1'b1 || dq_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err: err=%b oe=%b, expected 1 0", cmd_err, dq_oe);
    end
    @(negedge mem_clk);
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: err=%b, expected 0", cmd_err);
    end
    send(8'h05); send(8'h0B);
    n_checks++;
    if (dq_oe !== 1'b0 || busy !== 1'b1 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_ignore: oe=%b busy=%b err=%b, expected 0 1 0", dq_oe, busy, cmd_err);
    end
    cs_end();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_release: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_bus_conflict();
    read_start(32'h0000_0020);
    dq_oe_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus_conflict !== 1'b1) begin
        n_fail++;
        $display("FAIL conflict_on[%0d]: bus_conflict=%b, expected 1", i, bus_conflict);
      end
      @(negedge mem_clk);
      send(8'h00);
    end
    dq_oe_in = 1'b0; #1;
    n_checks++;
    if (bus_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_off: bus_conflict=%b, expected 0", bus_conflict);
    end
    cs_end();
    dq_oe_in = 1'b1; #1;
    n_checks++;
    if (bus_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_idle: bus_conflict=%b, expected 0", bus_conflict);
    end
    dq_oe_in = 1'b0;
    @(negedge mem_clk);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] exp [4];
    exp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    set_wel();
    prog_bytes(32'h0000_0010, 32'hC0C1_C2C3, 4);
    read_start(32'h0000_0010);
    send(8'h00);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (dq_oe !== 1'b0 || dqs !== 1'b0 || busy !== 1'b0 || dq_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: oe=%b dqs=%b busy=%b dq_out=%h, expected 0 0 0 00",
               dq_oe, dqs, busy, dq_out);
    end
    #1 reset = 1'b0;
    cs_n = 1'b1;
    @(negedge mem_clk);
    read_start(32'h0000_0010);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dq_out !== exp[i]) begin
        n_fail++;
        $display("FAIL reset_reread[%0d]: dq_out=%h, expected %h", i, dq_out, exp[i]);
      end
      if (i < 3) send(8'h00);
    end
    cs_end();
  endtask

  initial begin
    reset    = 1'b1;
    sclk_en  = 1'b0;
    cs_n     = 1'b1;
    dq_in    = 8'h00;
    dq_oe_in = 1'b0;
    repeat (2) @(negedge mem_clk);
    reset = 1'b0;
    @(negedge mem_clk);
    test_reset();
    test_wel_program();
    test_program_no_wel();
    test_page_wrap();
    test_read_wrap();
    test_abort();
    test_illegal();
    test_bus_conflict();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
